// File: rtl/std_sram_singleport_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// std_sram_singleport_arbiter_pkg
//   Shared definitions for the two-port single-port-SRAM arbiter.
//   - arb_port_e  : requester index, also used as the round-robin priority
//   - PRIO_RESET  : priority value after reset (port 0 wins the first tie)
//   - other_port(): the port that gets priority after the given one is granted
// -----------------------------------------------------------------------------
package std_sram_singleport_arbiter_pkg;

    typedef enum logic {
        ARB_PORT0 = 1'b0,
        ARB_PORT1 = 1'b1
    } arb_port_e;

    localparam arb_port_e PRIO_RESET = ARB_PORT0;

    function automatic arb_port_e other_port(input arb_port_e p);
        return (p == ARB_PORT0) ? ARB_PORT1 : ARB_PORT0;
    endfunction

endpackage

// File: rtl/std_sram_singleport_arbiter_if.sv
// -----------------------------------------------------------------------------
// std_sram_singleport_arbiter_if
//   One requester's view of the arbiter: a valid/ready request channel
//   (read or write) plus a buffered read-response channel with backpressure.
//   Modports:
//     master : the requesting agent (drives requests, consumes responses)
//     slave  : the arbiter (accepts requests, presents responses)
//   Signals:
//     req_valid  / req_ready   request handshake (ready = grant this cycle)
//     req_we                   1 = write, 0 = read
//     req_addr   / req_din     request address and write data
//     resp_valid / resp_ready  read-response handshake
//     resp_dout                read data
// -----------------------------------------------------------------------------
interface std_sram_singleport_arbiter_if #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_din;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_dout;

    modport master (
        output req_valid, req_we, req_addr, req_din, resp_ready,
        input  req_ready, resp_valid, resp_dout
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_din, resp_ready,
        output req_ready, resp_valid, resp_dout
    );

endinterface

// File: rtl/std_sram_singleport_arbiter_resp_slot.sv
// -----------------------------------------------------------------------------
// std_sram_singleport_arbiter_resp_slot
//   Per-port read tracking: remembers a read that is in flight in the SRAM,
//   captures its data the cycle after the grant, and holds it until the
//   consumer takes it.  Also reports whether a new read may be granted.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     read_grant   a read for this port is granted this cycle
//     sram_dout    SRAM read data (valid the cycle after read_grant)
//     resp_ready   consumer accepts resp data this cycle
//     rd_elig      a new read can be granted this cycle
//     resp_valid   resp_dout holds unconsumed read data
//     resp_dout    buffered read data
// -----------------------------------------------------------------------------
module std_sram_singleport_arbiter_resp_slot #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_grant,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    input  logic                  resp_ready,
    output logic                  rd_elig,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_dout
);

    logic                  inflight_q,   inflight_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_dout_q,  resp_dout_d;

    // A read may start only if nothing is in flight and the buffer will be
    // free by the time the data lands (empty now, or drained this cycle).
    assign rd_elig    = ~inflight_q & (~resp_valid_q | resp_ready);
    assign resp_valid = resp_valid_q;
    assign resp_dout  = resp_dout_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        inflight_d   = read_grant;
        resp_valid_d = resp_valid_q;
        resp_dout_d  = resp_dout_q;

        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end

        // The SRAM data is valid during the in-flight cycle; loading it takes
        // precedence over a pop in the same cycle.
        if (inflight_q) begin
            resp_valid_d = 1'b1;
            resp_dout_d  = sram_dout;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_dout_q  <= '0;
        end else begin
            inflight_q   <= inflight_d;
            resp_valid_q <= resp_valid_d;
            resp_dout_q  <= resp_dout_d;
        end
    end

endmodule

// File: rtl/std_sram_singleport_arbiter.sv
// -----------------------------------------------------------------------------
// std_sram_singleport_arbiter
//   Lets two pipeline agents share one synchronous single-port SRAM
//   (dout valid the cycle after en & ~we).  Each cycle at most one request is
//   granted, round-robin on contention; reads return through a buffered
//   response channel per port.
//   Ports:
//     clk, reset       clock, asynchronous active-high reset
//     port0, port1     requester channels (slave modport)
//     sram_en/we       SRAM enable / write enable
//     sram_addr/din    SRAM address / write data (0 when idle)
//     sram_dout        SRAM read data
// -----------------------------------------------------------------------------
module std_sram_singleport_arbiter
    import std_sram_singleport_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    std_sram_singleport_arbiter_if.slave  port0,
    std_sram_singleport_arbiter_if.slave  port1,
    output logic                          sram_en,
    output logic                          sram_we,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [DATA_WIDTH-1:0]         sram_din,
    input  logic [DATA_WIDTH-1:0]         sram_dout
);

    arb_port_e  prio_q, prio_d;
    logic [1:0] rd_elig;
    logic [1:0] elig;
    logic [1:0] grant;

    // Writes never wait on the response path; reads need a free slot.
    assign elig[0] = port0.req_valid & (port0.req_we | rd_elig[0]);
    assign elig[1] = port1.req_valid & (port1.req_we | rd_elig[1]);

    assign port0.req_ready = grant[0];
    assign port1.req_ready = grant[1];

    always_comb begin
        grant  = elig;
        prio_d = prio_q;

        if (elig[0] && elig[1]) begin
            grant = (prio_q == ARB_PORT0) ? 2'b01 : 2'b10;
        end

        if (grant[0]) begin
            prio_d = other_port(ARB_PORT0);
        end else if (grant[1]) begin
            prio_d = other_port(ARB_PORT1);
        end
    end

    always_comb begin
        sram_en   = |grant;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;

        if (grant[0]) begin
            sram_we   = port0.req_we;
            sram_addr = port0.req_addr;
            sram_din  = port0.req_din;
        end else if (grant[1]) begin
            sram_we   = port1.req_we;
            sram_addr = port1.req_addr;
            sram_din  = port1.req_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= PRIO_RESET;
        end else begin
            prio_q <= prio_d;
        end
    end

    std_sram_singleport_arbiter_resp_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot0 (
        .clk        (clk),
        .reset      (reset),
        .read_grant (grant[0] & ~port0.req_we),
        .sram_dout  (sram_dout),
        .resp_ready (port0.resp_ready),
        .rd_elig    (rd_elig[0]),
        .resp_valid (port0.resp_valid),
        .resp_dout  (port0.resp_dout)
    );

    std_sram_singleport_arbiter_resp_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot1 (
        .clk        (clk),
        .reset      (reset),
        .read_grant (grant[1] & ~port1.req_we),
        .sram_dout  (sram_dout),
        .resp_ready (port1.resp_ready),
        .rd_elig    (rd_elig[1]),
        .resp_valid (port1.resp_valid),
        .resp_dout  (port1.resp_dout)
    );

endmodule

// File: tb/tb_std_sram_singleport_arbiter.sv
// -----------------------------------------------------------------------------
// tb_std_sram_singleport_arbiter
//   Directed bench for the two-port SRAM arbiter with a behavioural
//   synchronous-read SRAM.  The driver checks grants/SRAM strobes each cycle
//   and queues the expected read data with its due cycle; a monitor pops and
//   compares whenever a port presents a new response.
// -----------------------------------------------------------------------------
module tb_std_sram_singleport_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    logic [DW-1:0] mem [16];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    std_sram_singleport_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_if ();
    std_sram_singleport_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_if ();

    std_sram_singleport_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .port0     (p0_if),
        .port1     (p1_if),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port SRAM: read data appears the cycle after en & ~we.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else         sram_dout      <= mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic req0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_if.req_valid = v;
        p0_if.req_we    = we;
        p0_if.req_addr  = a;
        p0_if.req_din   = d;
    endtask

    task automatic req1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_if.req_valid = v;
        p1_if.req_we    = we;
        p1_if.req_addr  = a;
        p1_if.req_din   = d;
    endtask

    // One cycle: check grants and SRAM drive mid-cycle, queue expected read
    // data for granted reads (due two cycles later), advance past the edge.
    task automatic tick(input logic eg0, input logic eg1, input logic [DW-1:0] ed0, input logic [DW-1:0] ed1);
        exp_t e;
        @(negedge clk);
        check("req0_ready", p0_if.req_ready, eg0);
        check("req1_ready", p1_if.req_ready, eg1);
        check("sram_en", sram_en, eg0 | eg1);
        if (eg0) begin
            check("sram_addr_p0", sram_addr, p0_if.req_addr);
            check("sram_we_p0", sram_we, p0_if.req_we);
            if (p0_if.req_we) check("sram_din_p0", sram_din, p0_if.req_din);
            else begin
                e.data = ed0;
                e.due  = cyc + 2;
                q0.push_back(e);
            end
        end else if (eg1) begin
            check("sram_addr_p1", sram_addr, p1_if.req_addr);
            check("sram_we_p1", sram_we, p1_if.req_we);
            if (p1_if.req_we) check("sram_din_p1", sram_din, p1_if.req_din);
            else begin
                e.data = ed1;
                e.due  = cyc + 2;
                q1.push_back(e);
            end
        end else begin
            check("sram_addr_idle", sram_addr, 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitors: a response is new when valid is seen and the previous
    // cycle did not end with an unconsumed response.
    logic prev_hold0 = 1'b0;
    logic prev_hold1 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset && p0_if.resp_valid && !prev_hold0) begin
            if (q0.size() == 0) check("resp0_unexpected", 1, 0);
            else begin
                e = q0.pop_front();
                check("resp0_dout", p0_if.resp_dout, e.data);
                check("resp0_cycle", cyc, e.due);
            end
        end
        prev_hold0 = !reset && p0_if.resp_valid && !p0_if.resp_ready;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && p1_if.resp_valid && !prev_hold1) begin
            if (q1.size() == 0) check("resp1_unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                check("resp1_dout", p1_if.resp_dout, e.data);
                check("resp1_cycle", cyc, e.due);
            end
        end
        prev_hold1 = !reset && p1_if.resp_valid && !p1_if.resp_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        sram_dout = '0;
        reset = 1'b1;
        req0(0, 0, 0, 0);
        req1(0, 0, 0, 0);
        p0_if.resp_ready = 1'b1;
        p1_if.resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp0_valid", p0_if.resp_valid, 0);
        check("rst_resp1_valid", p1_if.resp_valid, 0);
        check("rst_sram_en", sram_en, 0);
        check("rst_prio", dut.prio_q, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Preload: both write at once, port0 wins the first tie
        req0(1, 1, 2, 8'h11); req1(1, 1, 3, 8'hA5); tick(1, 0, 0, 0);
        req0(0, 0, 0, 0);                          tick(0, 1, 0, 0);
        req0(1, 1, 5, 8'hC3); req1(1, 1, 6, 8'h7E); tick(1, 0, 0, 0);
        req0(0, 0, 0, 0);                          tick(0, 1, 0, 0);
        req1(0, 0, 0, 0);                          tick(0, 0, 0, 0);

        // Contention: both ports reading back-to-back, grants alternate
        req0(1, 0, 3, 0); req1(1, 0, 2, 0); tick(1, 0, 8'hA5, 0);
        req0(1, 0, 5, 0);                   tick(0, 1, 0, 8'h11);
        req1(1, 0, 6, 0);                   tick(1, 0, 8'hC3, 0);
        req0(0, 0, 0, 0);                   tick(0, 1, 0, 8'h7E);
        req1(0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0);

        // Backpressure on port0's response path
        p0_if.resp_ready = 1'b0;
        req0(1, 0, 3, 0); req1(1, 1, 7, 8'h99); tick(1, 0, 8'hA5, 0);
        req0(1, 0, 5, 0);                      tick(0, 1, 0, 0);
        req1(1, 0, 6, 0);                      tick(0, 1, 0, 8'h7E);
        check("resp0_held", p0_if.resp_valid, 1);
        req1(0, 0, 0, 0);                      tick(0, 0, 0, 0);
        check("resp0_still_held", p0_if.resp_valid, 1);
        p0_if.resp_ready = 1'b1;               tick(1, 0, 8'hC3, 0);
        req0(0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0);

        // Write/read mix, and a write that proceeds while a read is in flight
        req1(1, 1, 1, 8'h5A);                  tick(0, 1, 0, 0);
        req0(1, 0, 1, 0); req1(1, 1, 8, 8'h42); tick(1, 0, 8'h5A, 0);
        req0(0, 0, 0, 0);                      tick(0, 1, 0, 0);
        req1(0, 0, 0, 0); req0(1, 0, 8, 0);    tick(1, 0, 8'h42, 0);
        req0(0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0);

        // Lone requester: port1 writes every cycle, priority returns to 0
        for (int i = 0; i < 4; i++) begin
            req1(1, 1, AW'(9 + i), DW'(8'h20 + i));
            tick(0, 1, 0, 0);
            check("lone_prio", dut.prio_q, 0);
        end
        req1(0, 0, 0, 0);
        req0(1, 0, 10, 0);                     tick(1, 0, 8'h21, 0);
        req0(0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0);

        // Reset while a port0 read is in flight: its response is dropped
        req0(1, 0, 3, 0);                      tick(1, 0, 8'hA5, 0);
        reset = 1'b1;
        req0(0, 0, 0, 0);
        q0.delete();
        @(negedge clk);
        check("midrst_resp0_valid", p0_if.resp_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_resp0_valid", p0_if.resp_valid, 0);
            check("post_rst_sram_en", sram_en, 0);
            check("post_rst_prio", dut.prio_q, 0);
            @(posedge clk);
            #1;
        end

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
